// File: rtl/counter_bank_pkg.sv
// rtl/counter_bank_pkg.sv - bounds, default widths and step encoding shared by counter_bank
package counter_bank_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_WIDTH = 32;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 24;

  // Sliced down to the channel width to form the wrap/saturate compare constants
  localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [MAX_WIDTH-1:0] ALL_ZERO = '0;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_INC,
    STEP_DEC,
    STEP_CLR
  } step_e;

endpackage

// File: rtl/counter_bank_ch.sv
// rtl/counter_bank_ch.sv - one channel: prescaler, prioritised counter, zero/compare/wrap pulses
// COUNTER_BANK_SATURATE_EN turns wrap-around into saturation with a blocked-step pulse.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [DIV_W-1:0] div_load,
  input  logic             ch_reset,
  input  logic             ch_disable,
  input  logic             ch_auto,
  input  logic             up_trig,
  input  logic             down_trig,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             zero_pulse,
  output logic             cmp_pulse,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] CNT_MAX  = ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_ZERO = ALL_ZERO[WIDTH-1:0];

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             zero_prev;
  logic             cmp_prev;
  logic             zero_cond;
  logic             cmp_cond;
  step_e            step;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  assign zero_cond = (count == CNT_ZERO);
  assign cmp_cond  = (count == cmp_val);

  always_comb begin
    step = STEP_HOLD;
    if (ch_reset)
      step = STEP_CLR;
    else if (up_trig)
      step = STEP_INC;
    else if (down_trig)
      step = STEP_DEC;
    else if (ch_auto && !ch_disable && tick)
      step = STEP_INC;
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    case (step)
      STEP_CLR: count_nxt = CNT_ZERO;
      STEP_INC: begin
        if (count == CNT_MAX) begin
          wrap_nxt = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
          count_nxt = CNT_MAX;
`else
          count_nxt = CNT_ZERO;
`endif
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      STEP_DEC: begin
        if (count == CNT_ZERO) begin
          wrap_nxt = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
          count_nxt = CNT_ZERO;
`else
          count_nxt = CNT_MAX;
`endif
        end else begin
          count_nxt = count - 1'b1;
        end
      end
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (div == '0) begin
      div  <= div_load;
      tick <= 1'b1;
    end else begin
      div  <= div - 1'b1;
      tick <= 1'b0;
    end
  end

  // Previous-condition flags reset high so leaving reset at count 0 does not pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      zero_prev  <= 1'b1;
      cmp_prev   <= 1'b1;
      zero_pulse <= 1'b0;
      cmp_pulse  <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= wrap_nxt;
      zero_prev  <= zero_cond;
      cmp_prev   <= cmp_cond;
      zero_pulse <= zero_cond && !zero_prev;
      cmp_pulse  <= cmp_cond && !cmp_prev;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of N_CH independent prescaled counters with event pulses
// Define COUNTER_BANK_SATURATE_EN for saturating counters instead of wrap-around.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_CH*DIV_W-1:0] div_load,
  input  logic [N_CH-1:0]       ch_reset,
  input  logic [N_CH-1:0]       ch_disable,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       up_trig,
  input  logic [N_CH-1:0]       down_trig,
  input  logic [N_CH*WIDTH-1:0] cmp_val,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       zero_pulse,
  output logic [N_CH-1:0]       cmp_pulse,
  output logic [N_CH-1:0]       wrap_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH(WIDTH),
      .DIV_W(DIV_W)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .div_load  (div_load[i*DIV_W +: DIV_W]),
      .ch_reset  (ch_reset[i]),
      .ch_disable(ch_disable[i]),
      .ch_auto   (ch_auto[i]),
      .up_trig   (up_trig[i]),
      .down_trig (down_trig[i]),
      .cmp_val   (cmp_val[i*WIDTH +: WIDTH]),
      .count     (count[i*WIDTH +: WIDTH]),
      .zero_pulse(zero_pulse[i]),
      .cmp_pulse (cmp_pulse[i]),
      .wrap_pulse(wrap_pulse[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed table and sequence checks for counter_bank (2 ch, 8-bit)
module tb_counter_bank;

`ifdef COUNTER_BANK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic [47:0] div_load;
  logic [1:0]  ch_reset;
  logic [1:0]  ch_disable;
  logic [1:0]  ch_auto;
  logic [1:0]  up_trig;
  logic [1:0]  down_trig;
  logic [15:0] cmp_val;
  logic [15:0] count;
  logic [1:0]  zero_pulse;
  logic [1:0]  cmp_pulse;
  logic [1:0]  wrap_pulse;

  int checks;
  int failures;

  counter_bank #(.N_CH(2), .WIDTH(8), .DIV_W(24)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .div_load  (div_load),
    .ch_reset  (ch_reset),
    .ch_disable(ch_disable),
    .ch_auto   (ch_auto),
    .up_trig   (up_trig),
    .down_trig (down_trig),
    .cmp_val   (cmp_val),
    .count     (count),
    .zero_pulse(zero_pulse),
    .cmp_pulse (cmp_pulse),
    .wrap_pulse(wrap_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic [7:0] cnt;
    logic       wrap;
    logic       zero;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    bit synced;
    checks = 0;
    failures = 0;
    sys_rst_n  = 1'b0;
    div_load   = {24'd0, 24'd3};
    ch_reset   = '0;
    ch_disable = '0;
    ch_auto    = '0;
    up_trig    = '0;
    down_trig  = '0;
    cmp_val    = {8'h80, 8'h80};

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, SAT ? 8'd0 : 8'd255, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, SAT ? 8'd0 : 8'd255, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, SAT ? 8'd1 : 8'd0, !SAT, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, SAT ? 8'd1 : 8'd0, 1'b0, !SAT};
    vecs[10] = '{1'b0, 1'b0, 1'b0, SAT ? 8'd1 : 8'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, SAT};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

    // Reset exit: counts zero and no pulses for 10 cycles
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_state", {count, zero_pulse, cmp_pulse, wrap_pulse}, 32'h0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_exit_quiet", {count, zero_pulse, cmp_pulse, wrap_pulse}, 32'h0);
    end

    // Trigger/priority/wrap table on ch0
    for (int i = 0; i < 14; i++) begin
      ch_reset[0]  = vecs[i].rst;
      up_trig[0]   = vecs[i].up;
      down_trig[0] = vecs[i].dn;
      step();
      chk($sformatf("vec%0d_count", i), {24'h0, count[7:0]}, {24'h0, vecs[i].cnt});
      chk($sformatf("vec%0d_pulses", i), {29'h0, wrap_pulse[0], zero_pulse[0], cmp_pulse[0]},
          {29'h0, vecs[i].wrap, vecs[i].zero, 1'b0});
    end
    ch_reset = '0;
    up_trig = '0;
    down_trig = '0;

    // Prescaler: ch0 div_load=3 ticks every 4 cycles; ch1 stays idle
    ch_auto[0] = 1'b1;
    synced = 1'b0;
    for (int i = 0; i < 8 && !synced; i++) begin
      step();
      if (count[7:0] == 8'd1) synced = 1'b1;
    end
    chk("presc_first_tick", {31'h0, synced}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        chk("presc_hold", {24'h0, count[7:0]}, k);
      end
      step();
      chk("presc_inc", {24'h0, count[7:0]}, k + 1);
    end
    chk("ch1_unaffected", {24'h0, count[15:8]}, 32'h0);
    ch_disable[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("disable_hold", {24'h0, count[7:0]}, 32'd4);
    end
    ch_disable[0] = 1'b0;
    ch_auto[0] = 1'b0;

    // Priority on ch1 (tick every cycle): up+down+tick on 5 -> 6, reset beats up
    ch_auto[1] = 1'b1;
    repeat (5) step();
    chk("prio_count5", {24'h0, count[15:8]}, 32'd5);
    up_trig[1] = 1'b1;
    down_trig[1] = 1'b1;
    step();
    chk("prio_up_wins", {24'h0, count[15:8]}, 32'd6);
    down_trig[1] = 1'b0;
    ch_reset[1] = 1'b1;
    step();
    chk("prio_reset_wins", {24'h0, count[15:8]}, 32'd0);
    up_trig[1] = 1'b0;
    ch_reset[1] = 1'b0;

    // Wrap / saturate on ch1
    repeat (255) step();
    ch_auto[1] = 1'b0;
    step();
    chk("ch1_at_max", {24'h0, count[15:8]}, 32'd255);
    up_trig[1] = 1'b1;
    step();
    chk("up1_count", {24'h0, count[15:8]}, SAT ? 32'd255 : 32'd0);
    chk("up1_wrap", {31'h0, wrap_pulse[1]}, 32'h1);
    up_trig[1] = SAT;
    step();
    chk("up2_count", {24'h0, count[15:8]}, SAT ? 32'd255 : 32'd0);
    chk("up2_wrap", {31'h0, wrap_pulse[1]}, {31'h0, SAT});
    chk("up2_zero", {31'h0, zero_pulse[1]}, {31'h0, !SAT});
    up_trig[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("after_wrap_quiet", {30'h0, wrap_pulse[1], zero_pulse[1]}, 32'h0);
    end
    down_trig[1] = 1'b1;
    step();
    chk("down_count", {24'h0, count[15:8]}, SAT ? 32'd254 : 32'd255);
    chk("down_wrap", {31'h0, wrap_pulse[1]}, {31'h0, !SAT});
    down_trig[1] = 1'b0;

    // Compare on ch0: tick every cycle, auto-count from 0x7E past 0x80
    ch_reset[0] = 1'b1;
    div_load[23:0] = 24'd0;
    step();
    ch_reset[0] = 1'b0;
    repeat (5) step();
    ch_auto[0] = 1'b1;
    repeat (126) step();
    chk("cmp_start", {24'h0, count[7:0]}, 32'h7E);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cmp_seq_count", {24'h0, count[7:0]}, 32'h7F + i);
      chk("cmp_seq_pulse", {31'h0, cmp_pulse[0]}, (i == 2) ? 32'h1 : 32'h0);
    end
    ch_auto[0] = 1'b0;
    step();
    chk("cmp_hold_count", {24'h0, count[7:0]}, 32'h82);
    chk("cmp_hold_pulse", {31'h0, cmp_pulse[0]}, 32'h0);
    cmp_val[7:0] = 8'h82;
    step();
    chk("cmp_change_pulse", {31'h0, cmp_pulse[0]}, 32'h1);
    step();
    chk("cmp_change_once", {31'h0, cmp_pulse[0]}, 32'h0);

    // Asynchronous reset mid-count clears immediately
    ch_auto = 2'b11;
    repeat (10) step();
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset", {count, zero_pulse, cmp_pulse, wrap_pulse}, 32'h0);
    ch_auto = '0;
    step();
    sys_rst_n = 1'b1;
    step();
    chk("post_reset_quiet", {count, zero_pulse, cmp_pulse, wrap_pulse}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of N_CH independent counters, all on `sys_clk`, each with its own prescaler, level controls, up/down trigger pulses, programmable compare value and single-cycle event pulses. It generalises the two fixed 8-bit host-controlled counters into one configurable block. Control and status connect to host wire-in, trigger-in, wire-out and trigger-out endpoints at the top level.

## Interface
- `N_CH`, default 2: number of counter channels (1–16).
- `WIDTH`, default 8: counter width in bits (2–32).
- `DIV_W`, default 24: prescaler width in bits (1–32).
- `sys_clk  in  1`: sole clock; all logic is rising-edge.
- `sys_rst_n  in  1`: reset, asynchronous assert, active-low. Deassertion must be synchronised to `sys_clk` externally.
- `div_load  in  N_CH*DIV_W`: per-channel prescaler reload value. Channel i uses bits [i*DIV_W +: DIV_W].
- `ch_reset  in  N_CH`: level; forces the channel count to 0.
- `ch_disable  in  N_CH`: level; blocks auto-count ticks only.
- `ch_auto  in  N_CH`: level; enables counting up on prescaler ticks.
- `up_trig  in  N_CH`: one-cycle pulse; increments the count.
- `down_trig  in  N_CH`: one-cycle pulse; decrements the count.
- `cmp_val  in  N_CH*WIDTH`: per-channel compare value.
- `count  out  N_CH*WIDTH`: registered counts.
- `zero_pulse  out  N_CH`: pulses on entry to count == 0.
- `cmp_pulse  out  N_CH`: pulses on entry to count == cmp_val.
- `wrap_pulse  out  N_CH`: pulses on a max→0 or 0→max transition.

## Operation
- **Prescaler, per channel**
  - Down-counter `div`. When `div` == 0 it reloads from `div_load` and sets `tick` for exactly one cycle; otherwise it decrements and clears `tick`.
  - Tick period is therefore `div_load` + 1 cycles. `div_load` = 0 gives a tick every cycle.
  - A changed `div_load` takes effect at the next reload.
- **Count update, per channel.** Priority, highest first:
  1. `ch_reset` → 0.
  2. `up_trig` → +1.
  3. `down_trig` → −1.
  4. `ch_auto` & !`ch_disable` & `tick` → +1.
  5. Otherwise hold.
- Simultaneous `up_trig` and `down_trig`: up wins and down is discarded.
- `ch_disable` does not gate triggers or reset.
- Arithmetic is modulo 2^WIDTH.
- **`wrap_pulse`**: asserted when an increment takes the count from all-ones to 0, or a decrement takes it from 0 to all-ones. Reset to 0 is not a wrap.
- **Event pulses**
  - Each equality condition (count == 0, count == `cmp_val`) is registered every cycle.
  - The pulse is condition & !previous_condition, so it is one cycle per entry.
  - Holding the value gives no repeat pulse.
  - A change of `cmp_val` to equal the current count produces a pulse.
- **Reset**
  - All `count` = 0, all `div` = 0, `tick` = 0, and all pulses = 0.
  - The previous-condition registers reset to 1, so there is no `zero_pulse` on exit from reset.
  - Assertion mid-operation clears everything immediately (asynchronous); no state survives.

## Timing
- Control sampled at edge k → `count` updated at edge k+1.
- `wrap_pulse` is registered alongside the count update, so it is also valid at k+1.
- `zero_pulse` and `cmp_pulse` are valid at k+2 (one cycle after `count` shows the value).
- First tick after reset release: `div` = 0 at the first edge triggers the reload, so `tick` is high during cycle 1.
- Channels are fully independent. There is no cross-channel combinational path.

## Configuration
- **`COUNTER_BANK_SATURATE_EN` defined:**
  - Increment at all-ones holds at all-ones, and decrement at 0 holds at 0.
  - `wrap_pulse` becomes a saturation-attempt pulse: one cycle for each blocked step.
- **Not defined:** wrap-around as above.

## Structure
- **Package `counter_bank_pkg`:**
  - Parameter bounds (`MAX_CH` = 16, `MAX_WIDTH` = 32).
  - Default widths.
  - Local constants for all-ones / zero compare helpers.
- **Sub-module `counter_bank_ch`:** one channel (prescaler, count, three pulse generators). The top instantiates `N_CH` copies in a generate loop and slices the packed buses.

## Test plan
- **Reset exit:** release `sys_rst_n` with `ch_auto` = 0.
  - Required: all counts 0.
  - Required: no pulses for 10 cycles.
- **Prescaler and auto-count:** ch0 `div_load` = 3, `ch_auto` = 1.
  - Required: ch0 increments every 4 cycles.
  - Required: with `ch_disable` high it holds.
  - Required: ch1 is unaffected.
- **Priority:** same-cycle `up_trig` + `down_trig` + `tick` on count 5.
  - Required: count 6.
  - Required: `ch_reset` with `up_trig` gives 0.
- **Wrap (macro off):** WIDTH = 8, count 255, `up_trig`.
  - Required: count 0 and `wrap_pulse` at k+1.
  - Required: `zero_pulse` at k+2, once only.
  - Required: `down_trig` gives 255 plus `wrap_pulse`.
- **Compare:** `cmp_val` = 0x80, auto-count from 0x7E.
  - Required: a single `cmp_pulse` one cycle after count shows 0x80.
  - Required: `cmp_val` changed to the current count gives a pulse.
- **Saturate (macro on):** count 255, `up_trig` ×2.
  - Required: count stays 255.
  - Required: two `wrap_pulse` cycles.
  - Required: asserting `sys_rst_n` low mid-count immediately gives count 0.
